fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port (`w_en`/`wdata`, gated by the write-pointer block's `full`) between `NUM_REQ` producers. Each producer uses a valid/ready handshake. Grants are bursts of at most `MAX_BURST` words, so no producer can starve the others. The block sits in the `wclk` domain directly in front of the write-pointer logic and the FIFO memory write port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum words written per grant, 1..255.
- `wclk` input 1: write-domain clock; all logic on rising edge.
- `w_rst` input 1: synchronous, active-high reset.
- `req_valid` input `NUM_REQ`: bit i set means requester i presents a word.
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i's word in slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` output `NUM_REQ`: one-hot or zero; a word transfers when `req_valid[i] & req_ready[i]`.
- `full` input 1: registered FIFO-full flag from the write-pointer block.
- `w_en` output 1: FIFO write enable.
- `wdata` output `DATA_WIDTH`: FIFO write data.
- `grant_id` output `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `busy` output 1: high while in BURST.

## Operation
- Two states: IDLE and BURST.
- **IDLE**
  - `req_ready` = 0 and `w_en` = 0.
  - If any `req_valid` is set, select the first set bit searching circularly from `rr_ptr`.
  - Register that index into `grant_id`, clear `burst_cnt`, and go to BURST.
  - If no `req_valid` is set, stay in IDLE.
- **BURST** (g = `grant_id`)
  - `req_ready[g]` = `!full`; all other `req_ready` bits are 0.
  - `w_en` = `req_valid[g] & !full`.
  - `wdata` = `req_data[g]`. Data is don't-care when `w_en` is 0.
  - Each cycle with `w_en` = 1 increments `burst_cnt` by one.
- **Leaving BURST**
  - Return to IDLE after the transfer that makes `burst_cnt` equal `MAX_BURST`.
  - Also return to IDLE on any cycle with `full` = 0 and `req_valid[g]` = 0 (the requester dropped out).
  - On either exit, `rr_ptr` becomes (g+1) mod `NUM_REQ`.
- **Full stall:** while `full` = 1 the block holds BURST. The cycle counts as neither a transfer nor an exit, so the grant persists across back-pressure.
- **Arithmetic:**
  - `burst_cnt` is `$clog2(MAX_BURST+1)` bits wide and never exceeds `MAX_BURST`.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.
- **Simultaneous events**
  - Exit on `MAX_BURST` and a new request from the same requester in the same cycle: IDLE is still entered, and the next grant starts from g+1.
  - `full` rising in the same cycle as the final transfer: the transfer already happened and the exit proceeds.
- **Reset**
  - Takes effect at the next `wclk` edge.
  - Values: state = IDLE, `rr_ptr` = 0, `burst_cnt` = 0, `grant_id` = 0, `busy` = 0, `req_ready` = 0, `w_en` = 0, `wdata` = 0.
  - `req_ready`, `w_en` and `wdata` are 0 during every cycle `w_rst` is high.
  - A reset mid-burst aborts the burst with no further writes.

## Timing
- Arbitration latency is one cycle: a `req_valid` seen in IDLE at edge N gives `req_ready` high in cycle N+1.
- Each grant costs one IDLE cycle, so peak throughput is `MAX_BURST`/(`MAX_BURST`+1) words per cycle.
- `req_ready`, `w_en` and `wdata` are combinational from registered state, `full`, `req_valid` and `req_data`. There is no combinational path from `req_valid` to `req_ready`.
- Requesters must hold `req_valid` and `req_data` stable until the transfer completes, or until they deliberately withdraw.

## Structure
- Package `fifo_arb_pkg`:
  - `typedef enum logic {IDLE, BURST} arb_state_t`.
  - Default-parameter localparams.
- Sub-module `rr_select`: purely combinational. It takes a `NUM_REQ` request vector and a start pointer, and returns a found flag plus an index. It is instantiated once, in the arbiter.

## Test plan
- Single requester: `NUM_REQ`=4, `MAX_BURST`=4, only `req_valid[2]` held high with data 0x10..0x17. Expect `grant_id`=2 and writes 0x10–0x13, then one idle cycle, then 0x14–0x17.
- All four valid continuously from reset. Expect grant order 0,1,2,3,0 with exactly 4 `w_en` pulses per grant and one gap cycle between grants.
- Back-pressure: `full`=1 for 3 cycles during the 2nd word of requester 1's burst. Expect `w_en`=0 and `req_ready[1]`=0 for those cycles, then the burst resumes with 4 total words and the same grant.
- Early withdrawal: requester 3 drops `req_valid` after 2 words with requesters 0 and 3 active. Expect IDLE next, then a grant to 0 (`rr_ptr` wraps 3→0).
- Mid-burst reset: `w_rst`=1 for one cycle after 1 word. Expect `w_en`=0 and `req_ready`=0 that cycle, `grant_id`=0, and with all requests active the next grant goes to requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request bit at or after start, wrapping.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk the request vector circularly from start and keep the first hit.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos     = (32'(start) + off) % NUM_REQ;
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port between NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          wclk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(MAX_BURST);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0] sel_idx, ptr_after;
    logic             sel_found;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req   (req_valid),
        .start (rr_ptr_q),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Port-side outputs: driven only in BURST and forced quiet while reset is asserted.
    always_comb begin
        req_ready = '0;
        w_en      = 1'b0;
        wdata     = '0;
        if (!w_rst && state_q == BURST) begin
            req_ready[grant_q] = !full;
            w_en               = req_valid[grant_q] & !full;
            wdata              = data_arr[grant_q];
        end
    end

    assign cnt_inc   = cnt_q + 1'b1;
    assign ptr_after = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    // Next-state logic: grant on any request in IDLE, leave BURST on burst limit or withdrawal.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (w_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_LEN) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_after;
                    end
                end else if (!full && !req_valid[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge wclk) begin
        if (w_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy     = (state_q == BURST);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int MAXB    = 4;
    localparam int IW      = 2;
    localparam int OW      = 1 + IW + NUM_REQ + 1 + DW;

    logic                     wclk = 1'b0;
    logic                     w_rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DW-1:0]    req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     full;
    logic                     w_en;
    logic [DW-1:0]            wdata;
    logic [IW-1:0]            grant_id;
    logic                     busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DW),
        .MAX_BURST (MAXB)
    ) dut (
        .wclk     (wclk),
        .w_rst    (w_rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .w_en     (w_en),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: active grant, words written in it, next search start.
    bit  m_busy;
    int  m_g, m_cnt, m_ptr;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_wen;
    logic [DW-1:0]      exp_wdata;

    // Producer model: each requester sends base+count and may withdraw after N words.
    int  src_base [NUM_REQ];
    int  src_cnt  [NUM_REQ];
    int  withdraw_at [NUM_REQ];
    bit  rand_mode;
    logic [NUM_REQ-1:0] xfer;

    int wr_gid[$];
    int wr_dat[$];

    function automatic logic [OW-1:0] obs_vec();
        return {busy, grant_id, req_ready, w_en, (w_en || w_rst) ? wdata : 8'h00};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {m_busy, IW'(m_g), exp_ready, exp_wen, exp_wdata};
    endfunction

    task automatic set_data(input int i, input int v);
        req_data[i*DW +: DW] = DW'(v);
    endtask

    task automatic model_eval();
        exp_ready = '0;
        exp_wen   = 1'b0;
        exp_wdata = '0;
        if (!w_rst && m_busy) begin
            exp_ready[m_g] = !full;
            exp_wen        = req_valid[m_g] && !full;
            if (exp_wen) exp_wdata = req_data[m_g*DW +: DW];
        end
    endtask

    task automatic model_clock();
        bit hit;
        if (w_rst) begin
            m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            hit = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!hit && req_valid[(m_ptr + k) % NUM_REQ]) begin
                    hit = 1;
                    m_g = (m_ptr + k) % NUM_REQ;
                    m_cnt = 0;
                    m_busy = 1;
                end
            end
        end else if (!full) begin
            if (req_valid[m_g]) begin
                m_cnt++;
                if (m_cnt == MAXB) begin
                    m_busy = 0;
                    m_ptr = (m_g + 1) % NUM_REQ;
                end
            end else begin
                m_busy = 0;
                m_ptr = (m_g + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic update_producers();
        if (rand_mode) return;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                src_cnt[i]++;
                set_data(i, src_base[i] + src_cnt[i]);
                if (withdraw_at[i] != 0 && src_cnt[i] == withdraw_at[i]) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic sample();
        @(negedge wclk);
        model_eval();
        xfer = req_valid & req_ready;
        if (w_en) begin
            wr_gid.push_back(int'(grant_id));
            wr_dat.push_back(int'(wdata));
        end
    endtask

    task automatic advance();
        @(posedge wclk);
        model_clock();
        #1;
        update_producers();
    endtask

    task automatic setup_src(input int i, input int base);
        src_base[i] = base;
        src_cnt[i]  = 0;
        set_data(i, base);
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        req_valid = '0;
        full = 1'b0;
        rand_mode = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            withdraw_at[i] = 0;
            setup_src(i, 0);
        end
        sample();
        advance();
        w_rst = 1'b0;
        wr_gid.delete();
        wr_dat.delete();
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        full = 1'b0;
        req_valid = '1;
        req_data = {8'hC0, 8'h80, 8'h40, 8'h01};
        sample();
        checks++;
        if (req_ready !== '0 || w_en !== 1'b0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b w_en=%b wdata=%h expected 0/0/00", req_ready, w_en, wdata);
        end
        advance();
        w_rst = 1'b0;
        req_valid = '0;
        sample();
        checks++;
        if (busy !== 1'b0 || grant_id !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b grant_id=%0d expected 0/0", busy, grant_id);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_single();
        do_reset();
        setup_src(2, 8'h10);
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (wr_dat.size() != 8) begin
            errors++;
            $display("FAIL single_count: got %0d writes expected 8", wr_dat.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wr_gid[k] != 2 || wr_dat[k] != 8'h10 + k) begin
                    errors++;
                    $display("FAIL single_word %0d: got id=%0d data=%h expected id=2 data=%h", k, wr_gid[k], wr_dat[k], 8'h10 + k);
                end
            end
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) setup_src(i, i * 8'h40);
        req_valid = '1;
        for (int c = 0; c < 25; c++) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_four cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (wr_gid.size() != 20) begin
            errors++;
            $display("FAIL all_four_count: got %0d writes expected 20", wr_gid.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                checks++;
                if (wr_gid[k] != (k / 4) % 4 || wr_dat[k] != ((k / 4) % 4) * 8'h40 + 4 * (k / 16) + k % 4) begin
                    errors++;
                    $display("FAIL all_four_order %0d: got id=%0d data=%h expected id=%0d", k, wr_gid[k], wr_dat[k], (k / 4) % 4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        setup_src(1, 8'h50);
        req_valid = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            full = (c >= 2 && c <= 4);
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (full) begin
                checks++;
                if (w_en !== 1'b0 || req_ready[1] !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall cycle %0d: got w_en=%b ready1=%b id=%0d busy=%b expected 0/0/1/1", c, w_en, req_ready[1], grant_id, busy);
                end
            end
            advance();
        end
        full = 1'b0;
        checks++;
        if (wr_dat.size() != 4 || wr_dat[0] != 8'h50 || wr_dat[3] != 8'h53 || wr_gid[3] != 1) begin
            errors++;
            $display("FAIL backpressure_burst: got %0d writes expected 4 words 50..53 from id 1", wr_dat.size());
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        setup_src(3, 8'h30);
        setup_src(0, 8'h60);
        withdraw_at[3] = 2;
        req_valid = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) req_valid[0] = 1'b1;
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL withdraw cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL withdraw_idle: got busy=%b expected 0", busy);
                end
            end
            advance();
        end
        checks++;
        if (wr_gid.size() != 5 || wr_gid[0] != 3 || wr_gid[1] != 3 || wr_gid[2] != 0) begin
            errors++;
            $display("FAIL withdraw_order: got %0d writes expected 3,3,0,0,0", wr_gid.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) setup_src(i, 8'h70 + i * 8'h10);
        req_valid = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            w_rst = (c == 2);
            if (c == 2) req_valid = '1;
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (c == 2) begin
                checks++;
                if (w_en !== 1'b0 || req_ready !== '0) begin
                    errors++;
                    $display("FAIL mid_reset_quiet: got w_en=%b ready=%b expected 0/0000", w_en, req_ready);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (grant_id !== '0 || busy !== (c == 4)) begin
                    errors++;
                    $display("FAIL mid_reset_grant cycle %0d: got id=%0d busy=%b expected 0/%0d", c, grant_id, busy, c == 4);
                end
            end
            advance();
        end
        w_rst = 1'b0;
        checks++;
        if (wr_gid.size() != 3 || wr_gid[0] != 2 || wr_gid[1] != 0) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d writes expected id 2 then id 0", wr_gid.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, $urandom_range(0, 255));
        for (int c = 0; c < 800; c++) begin
            full  = ($urandom_range(0, 3) == 0);
            w_rst = ($urandom_range(0, 99) == 0);
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            advance();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) begin
                    set_data(i, $urandom_range(0, 255));
                    req_valid[i] = 1'($urandom_range(0, 1));
                end else if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    if (req_valid[i]) set_data(i, $urandom_range(0, 255));
                end else if ($urandom_range(0, 30) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        w_rst = 1'b0;
        full = 1'b0;
        rand_mode = 0;
    endtask

    initial begin
        m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        rand_mode = 0;
        xfer = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_base[i] = 0; src_cnt[i] = 0; withdraw_at[i] = 0;
        end
        w_rst = 1'b1;
        full = 1'b0;
        req_valid = '0;
        req_data = '0;
        #1;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_withdraw();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
